noc_local_ni: RTL and testbench
===============================

// Module: noc_local_ni
// PURPOSE
//  Network interface on one router's LOCAL port in the NoC mesh. Sits between a core and the mesh.
//  TX side packetizes core requests into Phoenix packets: header flit = dest {X,Y}, size flit = N, then N payload flits.
//  TX drives the router's local rx/data and obeys the router's credit. RX side accepts flits from the router's local tx/data.
//  RX buffers them, returns credit, and presents them to the core with start/end-of-packet marks.
// PARAMETERS
//  TAM_FLIT     16  flit width in bits (equals `TAM_FLIT)
//  RX_DEPTH      4  RX FIFO entries, power of two, >=2
// PORTS
//  i_clk          in   1         sole clock
//  i_rst          in   1         asynchronous, active-low reset
//  i_req_valid    in   1         core requests a packet
//  i_req_dest     in   TAM_FLIT  target address {X,Y}
//  i_req_len      in   TAM_FLIT  payload flit count N
//  o_req_ready    out  1         request accepted when valid&ready
//  i_pl_valid     in   1         payload flit valid
//  i_pl_data      in   TAM_FLIT  payload flit
//  o_pl_ready     out  1         payload flit accepted when valid&ready
//  o_tx           out  1         flit valid toward router local rx
//  o_data         out  TAM_FLIT  flit toward router local data_in
//  i_credit       in   1         router local credit_o (space available)
//  i_rx           in   1         router local tx (flit valid)
//  i_data         in   TAM_FLIT  router local data_out
//  o_credit       out  1         credit toward router local credit_i
//  o_rx_valid     out  1         flit available to core
//  o_rx_data      out  TAM_FLIT  flit to core
//  o_rx_sof       out  1         flit is header
//  o_rx_eof       out  1         flit is last of packet
//  i_rx_ready     in   1         core pops flit when valid&ready
// BEHAVIOUR
//  Reset (i_rst=0, async): all outputs 0 except o_credit (0 during reset, 1 first cycle after). FSMs to IDLE, FIFO empty, counters 0.
//  Link transfer rule: a flit moves when o_tx&i_credit (TX) or i_rx&o_credit (RX); nothing else counts.
//  TX output register: o_tx/o_data are registered; o_data stable while o_tx=1 and i_credit=0.
//   Register loads when empty or its flit transfers in the same cycle (no bubble at full credit).
//  TX FSM: IDLE -> HDR -> SIZE -> PAYLD -> IDLE.
//   IDLE: o_req_ready=1. On accept, latch dest, len, and cnt=len; go HDR.
//   HDR: load dest into output reg; go SIZE.
//   SIZE: load len into output reg; go PAYLD, or IDLE if len==0 (two-flit packet).
//   PAYLD: o_pl_ready=1 iff output reg can load. On accept, load flit and cnt--.
//   PAYLD exits to IDLE after the flit that takes cnt to 0.
//  TX latency: request accept at cycle t -> o_tx=1 with header at t+2. Back-to-back packets need 1 IDLE cycle.
//  Core stalls (i_pl_valid=0) in PAYLD produce o_tx=0 bubbles; the packet is never aborted.
//  RX: o_credit = FIFO not full, registered. RX_DEPTH-1 occupancy with pending push deasserts next cycle.
//   Full FIFO never receives a push, because o_credit is derived from count including same-cycle push and pop.
//  RX framing counter on push side: idx0 header (sof=1), idx1 size (load rcnt).
//   Then rcnt payload flits. eof=1 on the size flit if size==0, else on the last payload flit.
//   sof/eof are stored per entry.
//  Simultaneous push and pop on full or empty FIFO: both occur; occupancy unchanged.
//  Empty FIFO: o_rx_valid=0, and o_rx_data/sof/eof are don't-care.
//  Arithmetic: counters are TAM_FLIT bits; len up to 2^TAM_FLIT-1. FIFO pointers wrap modulo RX_DEPTH.
//  Reset mid-packet abandons the packet on both sides. No partial-packet recovery is required.
// STRUCTURE
//  Constants TAM_FLIT, METADEFLIT, and the {X,Y} address packing come from defines.vh. The TX FSM state encoding is local.
//  Sub-module noc_ni_fifo: sync FIFO, width TAM_FLIT+2, depth RX_DEPTH, with count output. It is used for RX.
//  TX FSM, TX output register, and RX framing counter live in noc_local_ni.
// TESTING
//  T1: req dest=0x0102 len=3, payload A,B,C, i_credit=1 -> o_data 0102,0003,A,B,C on 5 consecutive cycles.
//  T2: as T1, with i_credit=0 for 4 cycles while the header is held -> o_data=0102 stable. Same sequence afterwards, no loss.
//  T3: len=0 -> exactly two flits (dest,0000), then o_req_ready=1 again.
//  T4: router sends 0201,0002,X,Y with i_rx_ready=0 -> o_credit falls after 4 pushes (RX_DEPTH=4).
//      Pops then yield sof on 0201 and eof on Y only.
//  T5: i_rst low during payload flit 2 -> all outputs 0 asynchronously. Next request after reset starts from a clean header.
//  T6: RX packet with size=0 overlapping a TX packet -> eof on the size flit; both directions run concurrently.

Source files
------------

// File: rtl/noc_local_ni_pkg.sv
// Shared constants and types for the NoC local network interface.
// Flit width and {X,Y} address packing follow the mesh-wide definitions.
package noc_local_ni_pkg;

    localparam int TAM_FLIT   = 16;
    localparam int METADEFLIT = TAM_FLIT / 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_HDR   = 2'd1,
        TX_SIZE  = 2'd2,
        TX_PAYLD = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_HDR   = 2'd0,
        RX_SIZE  = 2'd1,
        RX_PAYLD = 2'd2
    } rx_phase_t;

    function automatic logic [TAM_FLIT-1:0] xy_addr(input logic [METADEFLIT-1:0] x,
                                                    input logic [METADEFLIT-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/noc_ni_fifo.sv
// Synchronous FIFO with occupancy count; read data is the head entry (combinational).
// Depth must be a power of two so the pointers wrap naturally.
module noc_ni_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + AW'(1);
            if (i_pop)  rd_ptr <= rd_ptr + AW'(1);
            o_count <= o_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr] <= i_wdata;
    end

    assign o_rdata = mem[rd_ptr];

endmodule

// File: rtl/noc_local_ni.sv
// Network interface on a router LOCAL port: packetizes core requests toward the mesh
// and buffers/frames flits arriving from the mesh for the core.
//
//   TX state | meaning
//   ---------+----------------------------------------------------------
//   TX_IDLE  | ready for a new request; latches dest/len on accept
//   TX_HDR   | waiting to place the dest header flit in the output reg
//   TX_SIZE  | waiting to place the size flit; len==0 ends the packet
//   TX_PAYLD | forwarding payload flits until cnt reaches zero
module noc_local_ni
    import noc_local_ni_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    input  logic [TAM_FLIT-1:0] i_req_dest,
    input  logic [TAM_FLIT-1:0] i_req_len,
    output logic                o_req_ready,
    input  logic                i_pl_valid,
    input  logic [TAM_FLIT-1:0] i_pl_data,
    output logic                o_pl_ready,
    output logic                o_tx,
    output logic [TAM_FLIT-1:0] o_data,
    input  logic                i_credit,
    input  logic                i_rx,
    input  logic [TAM_FLIT-1:0] i_data,
    output logic                o_credit,
    output logic                o_rx_valid,
    output logic [TAM_FLIT-1:0] o_rx_data,
    output logic                o_rx_sof,
    output logic                o_rx_eof,
    input  logic                i_rx_ready
);

    localparam int CW = $clog2(RX_DEPTH) + 1;

    tx_state_t           state_q, state_d;
    logic [TAM_FLIT-1:0] dest_q, len_q, cnt_q;
    logic                tx_q;
    logic [TAM_FLIT-1:0] data_q;
    logic                alive_q;
    logic                can_load, load;
    logic [TAM_FLIT-1:0] load_data;
    logic                req_fire, pl_fire;

    // The output register may take a new flit when empty or when its flit leaves this cycle.
    assign can_load = !tx_q || i_credit;
    assign req_fire = i_req_valid && o_req_ready;
    assign pl_fire  = i_pl_valid && o_pl_ready;

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        load_data   = dest_q;
        o_req_ready = 1'b0;
        o_pl_ready  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                o_req_ready = alive_q;
                if (i_req_valid && alive_q) state_d = TX_HDR;
            end
            TX_HDR: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = dest_q;
                    state_d   = TX_SIZE;
                end
            end
            TX_SIZE: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = len_q;
                    state_d   = (len_q == '0) ? TX_IDLE : TX_PAYLD;
                end
            end
            TX_PAYLD: begin
                o_pl_ready = can_load;
                if (i_pl_valid && can_load) begin
                    load      = 1'b1;
                    load_data = i_pl_data;
                    if (cnt_q == TAM_FLIT'(1)) state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // alive_q keeps o_req_ready low while reset is asserted.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= TX_IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            data_q  <= '0;
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            state_q <= state_d;
            if (req_fire) begin
                dest_q <= i_req_dest;
                len_q  <= i_req_len;
                cnt_q  <= i_req_len;
            end
            if (pl_fire) cnt_q <= cnt_q - TAM_FLIT'(1);
            if (load) begin
                tx_q   <= 1'b1;
                data_q <= load_data;
            end else if (i_credit) begin
                tx_q <= 1'b0;
            end
        end
    end

    assign o_tx   = tx_q;
    assign o_data = data_q;

    rx_phase_t             rphase_q;
    logic [TAM_FLIT-1:0]   rcnt_q;
    logic                  rx_push, rx_pop, w_sof, w_eof, credit_q;
    logic [CW-1:0]         rx_count, rx_count_next;
    logic [TAM_FLIT+1:0]   rd_entry;

    assign rx_push       = i_rx && credit_q;
    assign rx_pop        = o_rx_valid && i_rx_ready;
    assign rx_count_next = rx_count + CW'(rx_push) - CW'(rx_pop);

    always_comb begin
        w_sof = 1'b0;
        w_eof = 1'b0;
        case (rphase_q)
            RX_HDR:   w_sof = 1'b1;
            RX_SIZE:  w_eof = (i_data == '0);
            RX_PAYLD: w_eof = (rcnt_q == TAM_FLIT'(1));
            default:  ;
        endcase
    end

    // Credit looks at the post-update occupancy, so a full FIFO is never offered a push.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rphase_q <= RX_HDR;
            rcnt_q   <= '0;
            credit_q <= 1'b0;
        end else begin
            credit_q <= (rx_count_next != CW'(RX_DEPTH));
            if (rx_push) begin
                case (rphase_q)
                    RX_HDR:  rphase_q <= RX_SIZE;
                    RX_SIZE: begin
                        rcnt_q   <= i_data;
                        rphase_q <= (i_data == '0) ? RX_HDR : RX_PAYLD;
                    end
                    RX_PAYLD: begin
                        rcnt_q <= rcnt_q - TAM_FLIT'(1);
                        if (rcnt_q == TAM_FLIT'(1)) rphase_q <= RX_HDR;
                    end
                    default: rphase_q <= RX_HDR;
                endcase
            end
        end
    end

    noc_ni_fifo #(
        .WIDTH (TAM_FLIT + 2),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (rx_push),
        .i_wdata ({w_sof, w_eof, i_data}),
        .i_pop   (rx_pop),
        .o_rdata (rd_entry),
        .o_count (rx_count)
    );

    assign o_credit   = credit_q;
    assign o_rx_valid = (rx_count != '0);
    assign {o_rx_sof, o_rx_eof, o_rx_data} = o_rx_valid ? rd_entry : '0;

endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni: directed scenarios plus randomized traffic checked against
// packet-level expected flit streams and an RX occupancy/credit model.
module tb_noc_local_ni;

    localparam int RX_DEPTH = 4;

    logic        i_clk, i_rst;
    logic        i_req_valid;
    logic [15:0] i_req_dest, i_req_len;
    logic        o_req_ready;
    logic        i_pl_valid;
    logic [15:0] i_pl_data;
    logic        o_pl_ready;
    logic        o_tx;
    logic [15:0] o_data;
    logic        i_credit;
    logic        i_rx;
    logic [15:0] i_data;
    logic        o_credit;
    logic        o_rx_valid;
    logic [15:0] o_rx_data;
    logic        o_rx_sof, o_rx_eof;
    logic        i_rx_ready;

    noc_local_ni #(.RX_DEPTH(RX_DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_dest  (i_req_dest),
        .i_req_len   (i_req_len),
        .o_req_ready (o_req_ready),
        .i_pl_valid  (i_pl_valid),
        .i_pl_data   (i_pl_data),
        .o_pl_ready  (o_pl_ready),
        .o_tx        (o_tx),
        .o_data      (o_data),
        .i_credit    (i_credit),
        .i_rx        (i_rx),
        .i_data      (i_data),
        .o_credit    (o_credit),
        .o_rx_valid  (o_rx_valid),
        .o_rx_data   (o_rx_data),
        .o_rx_sof    (o_rx_sof),
        .o_rx_eof    (o_rx_eof),
        .i_rx_ready  (i_rx_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] tx_exp[$];
    logic [17:0] rx_exp[$];
    int          tx_cyc_log[$];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          occ = 0;
    bit          exp_credit = 1'b0;
    bit          mon_on = 1'b0;
    int          cred_mode = 0;
    int          rdy_mode = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(o_req_ready), 32'd0);
        check({tag, "_pl_ready"},  32'(o_pl_ready),  32'd0);
        check({tag, "_tx"},        32'(o_tx),        32'd0);
        check({tag, "_data"},      32'(o_data),      32'd0);
        check({tag, "_credit"},    32'(o_credit),    32'd0);
        check({tag, "_rx_valid"},  32'(o_rx_valid),  32'd0);
        check({tag, "_rx_data"},   32'(o_rx_data),   32'd0);
        check({tag, "_rx_sof"},    32'(o_rx_sof),    32'd0);
        check({tag, "_rx_eof"},    32'(o_rx_eof),    32'd0);
    endtask

    // Link observer: every flit crossing either interface is compared against the expected streams.
    task automatic monitor();
        logic [17:0] e;
        bit          push, pop;
        forever begin
            @(negedge i_clk);
            if (mon_on) begin
                push = i_rx && o_credit;
                pop  = o_rx_valid && i_rx_ready;
                check("rx_valid_vs_occupancy", 32'(o_rx_valid), 32'(occ != 0));
                check("credit_vs_occupancy",   32'(o_credit),   32'(exp_credit));
                if (o_tx && i_credit) begin
                    tx_cyc_log.push_back(cyc);
                    if (tx_exp.size() == 0) check("tx_unexpected_flit", 32'(o_tx), 32'd0);
                    else check("tx_flit", 32'(o_data), 32'(tx_exp.pop_front()));
                end
                if (pop) begin
                    if (rx_exp.size() == 0) check("rx_unexpected_flit", 32'(o_rx_valid), 32'd0);
                    else begin
                        e = rx_exp.pop_front();
                        check("rx_flit_sof_eof_data", 32'({o_rx_sof, o_rx_eof, o_rx_data}), 32'(e));
                    end
                end
                occ = occ + int'(push) - int'(pop);
                exp_credit = (occ != RX_DEPTH);
            end
        end
    endtask

    task automatic send_tx(input logic [15:0] dest, input logic [15:0] len, input int stall);
        int budget;
        tx_exp.push_back(dest);
        tx_exp.push_back(len);
        @(posedge i_clk); #1;
        i_req_valid = 1'b1;
        i_req_dest  = dest;
        i_req_len   = len;
        budget = 0;
        forever begin
            @(negedge i_clk);
            if (o_req_ready) break;
            budget++;
            if (budget > 200) begin
                check("req_accept_timeout", 32'(o_req_ready), 32'd1);
                break;
            end
        end
        acc_cyc = cyc;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_req_dest  = 16'($urandom);
        i_req_len   = 16'($urandom);
        for (int k = 0; k < int'(len); k++) begin
            logic [15:0] d;
            d = 16'($urandom);
            tx_exp.push_back(d);
            i_pl_data  = d;
            i_pl_valid = ($urandom_range(99) >= stall);
            budget = 0;
            forever begin
                @(negedge i_clk);
                if (i_pl_valid && o_pl_ready) break;
                budget++;
                if (budget > 200) begin
                    check("pl_accept_timeout", 32'(o_pl_ready), 32'd1);
                    break;
                end
                @(posedge i_clk); #1;
                i_pl_valid = ($urandom_range(99) >= stall);
            end
            @(posedge i_clk); #1;
            i_pl_valid = 1'b0;
        end
    endtask

    task automatic send_rx(input logic [15:0] hdr, input logic [15:0] size, input int gap);
        logic [15:0] fl[$];
        int          budget;
        fl.push_back(hdr);
        fl.push_back(size);
        for (int k = 0; k < int'(size); k++) fl.push_back(16'($urandom));
        foreach (fl[k]) rx_exp.push_back({(k == 0), (k == fl.size() - 1), fl[k]});
        @(posedge i_clk); #1;
        foreach (fl[k]) begin
            i_data = fl[k];
            i_rx   = ($urandom_range(99) >= gap);
            budget = 0;
            forever begin
                @(negedge i_clk);
                if (i_rx && o_credit) break;
                budget++;
                if (budget > 300) begin
                    check("rx_link_timeout", 32'(o_credit), 32'd1);
                    break;
                end
                @(posedge i_clk); #1;
                i_rx = ($urandom_range(99) >= gap);
            end
            @(posedge i_clk); #1;
            i_rx = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int budget;
        cred_mode = 0;
        rdy_mode  = 0;
        budget    = 0;
        while ((tx_exp.size() != 0 || rx_exp.size() != 0) && budget < 600) begin
            @(posedge i_clk);
            budget++;
        end
        check("drain_tx_outstanding", 32'(tx_exp.size()), 32'd0);
        check("drain_rx_outstanding", 32'(rx_exp.size()), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    initial begin
        int budget;
        i_rst = 1'b0;
        i_req_valid = 1'b0; i_req_dest = '0; i_req_len = '0;
        i_pl_valid = 1'b0;  i_pl_data = '0;
        i_credit = 1'b1;    i_rx = 1'b0; i_data = '0; i_rx_ready = 1'b1;

        fork
            forever begin @(posedge i_clk); cyc++; end
            forever begin
                @(posedge i_clk); #1;
                if (cred_mode == 0) i_credit = 1'b1;
                else if (cred_mode == 1) i_credit = ($urandom_range(99) < 70);
            end
            forever begin
                @(posedge i_clk); #1;
                if (rdy_mode == 0) i_rx_ready = 1'b1;
                else if (rdy_mode == 1) i_rx_ready = ($urandom_range(99) < 60);
            end
            monitor();
        join_none

        // Reset state, then first cycle after release.
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); i_rst = 1'b1;
        @(posedge i_clk); #1;
        check("post_reset_credit",    32'(o_credit),    32'd1);
        check("post_reset_req_ready", 32'(o_req_ready), 32'd1);
        occ = 0; exp_credit = 1'b1; mon_on = 1'b1;

        // T1: full-credit packet, header at accept+2 and five consecutive flits.
        tx_cyc_log.delete();
        send_tx(16'h0102, 16'd3, 0);
        wait_drain();
        check("t1_flit_count", 32'(tx_cyc_log.size()), 32'd5);
        if (tx_cyc_log.size() >= 5) begin
            check("t1_header_latency", 32'(tx_cyc_log[0]), 32'(acc_cyc + 2));
            for (int i = 1; i < 5; i++)
                check("t1_consecutive", 32'(tx_cyc_log[i]), 32'(tx_cyc_log[0] + i));
        end

        // T2: header held under zero credit.
        cred_mode = 2; i_credit = 1'b0;
        fork
            send_tx(16'h0102, 16'd3, 0);
            begin
                budget = 0;
                do begin
                    @(negedge i_clk);
                    budget++;
                end while (!o_tx && budget < 20);
                check("t2_header_appears", 32'(o_tx), 32'd1);
                repeat (4) begin
                    @(negedge i_clk);
                    check("t2_hold_tx",   32'(o_tx),   32'd1);
                    check("t2_hold_data", 32'(o_data), 32'h0102);
                end
                @(posedge i_clk); #1;
                i_credit = 1'b1; cred_mode = 0;
            end
        join
        wait_drain();

        // T3: zero-length packet is header + size only.
        send_tx(16'h0304, 16'd0, 0);
        wait_drain();
        @(negedge i_clk);
        check("t3_req_ready_again", 32'(o_req_ready), 32'd1);

        // T4: fill RX FIFO with the core stalled; credit must drop and stay low.
        @(posedge i_clk); #1;
        rdy_mode = 2; i_rx_ready = 1'b0;
        send_rx(16'h0201, 16'd2, 0);
        @(negedge i_clk);
        check("t4_credit_full",   32'(o_credit),   32'd0);
        check("t4_rx_valid_full", 32'(o_rx_valid), 32'd1);
        @(posedge i_clk); #1;
        i_rx = 1'b1; i_data = 16'hdead;
        repeat (2) @(posedge i_clk);
        #1;
        i_rx = 1'b0;
        @(negedge i_clk);
        check("t4_credit_still_low", 32'(o_credit), 32'd0);
        wait_drain();

        // T5: asynchronous reset in the middle of payload flit 2.
        mon_on = 1'b0;
        @(posedge i_clk); #1;
        i_req_valid = 1'b1; i_req_dest = 16'h0a0b; i_req_len = 16'd4;
        budget = 0;
        do begin @(negedge i_clk); budget++; end while (!o_req_ready && budget < 20);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0; i_pl_valid = 1'b1; i_pl_data = 16'h1111;
        budget = 0;
        do begin @(negedge i_clk); budget++; end while (!o_pl_ready && budget < 20);
        @(posedge i_clk); #1;
        i_pl_data = 16'h2222;
        @(negedge i_clk); #2;
        i_rst = 1'b0;
        #1;
        check_reset_outputs("t5_async_reset");
        i_pl_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk); i_rst = 1'b1;
        @(posedge i_clk); #1;
        check("t5_credit_after",    32'(o_credit),    32'd1);
        check("t5_req_ready_after", 32'(o_req_ready), 32'd1);
        tx_exp.delete(); rx_exp.delete(); tx_cyc_log.delete();
        occ = 0; exp_credit = 1'b1; mon_on = 1'b1;
        send_tx(16'h0c0d, 16'd1, 0);
        wait_drain();
        check("t5_clean_packet_flits", 32'(tx_cyc_log.size()), 32'd3);
        if (tx_cyc_log.size() >= 1)
            check("t5_header_latency", 32'(tx_cyc_log[0]), 32'(acc_cyc + 2));

        // T6: zero-size RX packet concurrent with a TX packet.
        cred_mode = 1; rdy_mode = 1;
        fork
            send_rx(16'h0304, 16'd0, 20);
            send_tx(16'h0506, 16'd4, 20);
        join
        wait_drain();

        // Randomized bidirectional traffic.
        for (int p = 0; p < 10; p++) begin
            cred_mode = 1; rdy_mode = 1;
            fork
                send_tx(16'($urandom), 16'($urandom_range(0, 6)), 25);
                send_rx(16'($urandom), 16'($urandom_range(0, 6)), 30);
            join
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
